// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for 8x8 approximate unsigned multipliers: 3-stage
// pipeline (capture, error distance, accumulate) over a window of N_SAMPLES.
// Optional macro APPROX_ERR_SQ_EN adds a saturating sum of squared errors (sq_sum).
module approx_mult_err_monitor #(
    parameter int N_SAMPLES = 256,
    parameter int SUM_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         x,
    input  logic [7:0]         y,
    input  logic [15:0]        z,
    output logic               busy,
    output logic               done,
    output logic [SUM_W-1:0]   err_sum,
    output logic [15:0]        err_max,
    output logic [15:0]        err_cnt
`ifdef APPROX_ERR_SQ_EN
    ,
    output logic [SUM_W+15:0]  sq_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t            r_state;
    logic [15:0]       r_cnt;
    logic              r_busy;
    logic              r_done;

    logic              r_v1;
    logic [7:0]        r_x1;
    logic [7:0]        r_y1;
    logic [15:0]       r_z1;

    logic              r_v2;
    logic [15:0]       r_ed;
    logic              r_nz;

    logic [SUM_W-1:0]  r_sum;
    logic [15:0]       r_max;
    logic [15:0]       r_cnt_err;

    logic              w_accept;
    logic              w_clear;
    logic [15:0]       w_exact;
    logic [15:0]       w_ed;
    logic [SUM_W:0]    w_sum_ext;
    logic [SUM_W-1:0]  w_sum_nxt;

    assign in_ready = (r_state == S_ACCUM);
    assign w_accept = in_valid & in_ready;
    assign w_clear  = start & ((r_state == S_IDLE) | (r_state == S_DONE));

    assign busy    = r_busy;
    assign done    = r_done;
    assign err_sum = r_sum;
    assign err_max = r_max;
    assign err_cnt = r_cnt_err;

    // Window control FSM with registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_ACCUM;
                        r_cnt   <= 16'd0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 16'd1;
                        if (r_cnt == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last sample has committed once both pipeline valids are clear.
                    if (!r_v1 && !r_v2) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture accepted operand/product triples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_x1 <= 8'd0;
            r_y1 <= 8'd0;
            r_z1 <= 16'd0;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_x1 <= x;
                r_y1 <= y;
                r_z1 <= z;
            end
        end
    end

    // z is a full 16-bit value and may exceed 255*255, so the distance is taken both ways.
    always_comb begin
        w_exact = {8'd0, r_x1} * {8'd0, r_y1};
        w_ed    = abs_diff(w_exact, r_z1);
    end

    // Stage 2: register error distance and its nonzero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_ed <= 16'd0;
            r_nz <= 1'b0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_ed <= w_ed;
                r_nz <= (w_ed != 16'd0);
            end
        end
    end

    always_comb begin
        w_sum_ext = {1'b0, r_sum} + {{(SUM_W-15){1'b0}}, r_ed};
        if (w_sum_ext[SUM_W]) begin
            w_sum_nxt = {SUM_W{1'b1}};
        end else begin
            w_sum_nxt = w_sum_ext[SUM_W-1:0];
        end
    end

    // Stage 3: accumulate statistics; start in IDLE/DONE clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum     <= {SUM_W{1'b0}};
            r_max     <= 16'd0;
            r_cnt_err <= 16'd0;
        end else if (w_clear) begin
            r_sum     <= {SUM_W{1'b0}};
            r_max     <= 16'd0;
            r_cnt_err <= 16'd0;
        end else if (r_v2) begin
            r_sum     <= w_sum_nxt;
            r_max     <= (r_ed > r_max) ? r_ed : r_max;
            r_cnt_err <= r_cnt_err + {15'd0, r_nz};
        end
    end

`ifdef APPROX_ERR_SQ_EN
    logic [SUM_W+15:0] r_sq;
    logic [31:0]       w_sq;
    logic [SUM_W+16:0] w_sq_ext;
    logic [SUM_W+15:0] w_sq_nxt;

    assign sq_sum = r_sq;

    always_comb begin
        w_sq     = r_ed * r_ed;
        w_sq_ext = {1'b0, r_sq} + {{(SUM_W-15){1'b0}}, w_sq};
        if (w_sq_ext[SUM_W+16]) begin
            w_sq_nxt = {(SUM_W+16){1'b1}};
        end else begin
            w_sq_nxt = w_sq_ext[SUM_W+15:0];
        end
    end

    // Squared-error accumulator, aligned with stage 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= {(SUM_W+16){1'b0}};
        end else if (w_clear) begin
            r_sq <= {(SUM_W+16){1'b0}};
        end else if (r_v2) begin
            r_sq <= w_sq_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Scoreboard bench for approx_mult_err_monitor: four instances with different
// window lengths / sum widths, expected statistics modelled from driven samples.
module tb_approx_mult_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start_v = 4'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [7:0]  y = 8'd0;
    logic [15:0] z = 16'd0;

    logic [3:0]  ready_v, busy_v, done_v;
    logic [31:0] sum_a [4];
    logic [15:0] sum16;
    logic [15:0] max_a [4];
    logic [15:0] cnt_a [4];
`ifdef APPROX_ERR_SQ_EN
    logic [47:0] sq_a [4];
    logic [31:0] sq16;
    assign sq_a[2] = {16'd0, sq16};
`endif
    assign sum_a[2] = {16'd0, sum16};

    typedef struct {
        longint sum;
        longint mx;
        longint cnt;
        longint sq;
    } exp_t;
    exp_t sb_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int sx[16], sy[16], sz[16], vpat[16];
    int vlen = 0;

    always #5 clk = ~clk;

    approx_mult_err_monitor #(.N_SAMPLES(4), .SUM_W(32)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(ready_v[0]),
        .x(x), .y(y), .z(z), .busy(busy_v[0]), .done(done_v[0]),
        .err_sum(sum_a[0]), .err_max(max_a[0]), .err_cnt(cnt_a[0])
`ifdef APPROX_ERR_SQ_EN
        , .sq_sum(sq_a[0])
`endif
    );
    approx_mult_err_monitor #(.N_SAMPLES(3), .SUM_W(32)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(ready_v[1]),
        .x(x), .y(y), .z(z), .busy(busy_v[1]), .done(done_v[1]),
        .err_sum(sum_a[1]), .err_max(max_a[1]), .err_cnt(cnt_a[1])
`ifdef APPROX_ERR_SQ_EN
        , .sq_sum(sq_a[1])
`endif
    );
    approx_mult_err_monitor #(.N_SAMPLES(2), .SUM_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(ready_v[2]),
        .x(x), .y(y), .z(z), .busy(busy_v[2]), .done(done_v[2]),
        .err_sum(sum16), .err_max(max_a[2]), .err_cnt(cnt_a[2])
`ifdef APPROX_ERR_SQ_EN
        , .sq_sum(sq16)
`endif
    );
    approx_mult_err_monitor #(.N_SAMPLES(8), .SUM_W(32)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in_valid(in_valid), .in_ready(ready_v[3]),
        .x(x), .y(y), .z(z), .busy(busy_v[3]), .done(done_v[3]),
        .err_sum(sum_a[3]), .err_max(max_a[3]), .err_cnt(cnt_a[3])
`ifdef APPROX_ERR_SQ_EN
        , .sq_sum(sq_a[3])
`endif
    );

    task automatic open_window(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
        n_chk++;
        if (ready_v[idx] !== 1'b1 || busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL open_window[%0d]: ready/busy/done=%b%b%b required 110", idx, ready_v[idx], busy_v[idx], done_v[idx]);
        end
    endtask

    // Drives one window (already opened), models each acceptance, checks latency and results.
    task automatic run_window(input int idx, input int n, input int sw, input bit poke);
        exp_t   e, g;
        longint sum_max, sq_max, ed;
        int     acc = 0;
        int     cyc = 0;
        int     si = 0;
        bit     v;
        sum_max = (64'sd1 <<< sw) - 64'sd1;
        sq_max  = (64'sd1 <<< (sw + 16)) - 64'sd1;
        e = '{0, 0, 0, 0};
        while (acc < n && cyc < 100) begin
            @(negedge clk);
            n_chk++;
            if (ready_v[idx] !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_accum[%0d]: got %b required 1 (acc=%0d)", idx, ready_v[idx], acc);
            end
            v = (cyc < vlen) ? (vpat[cyc] != 0) : 1'b1;
            in_valid = v;
            if (v) begin
                x = 8'(sx[si]); y = 8'(sy[si]); z = 16'(sz[si]);
            end else begin
                x = 8'($urandom); y = 8'($urandom); z = 16'($urandom);
            end
            start_v[idx] = poke && (acc == 2);
            @(posedge clk);
            if (v) begin
                ed = longint'(sx[si]) * longint'(sy[si]) - longint'(sz[si]);
                if (ed < 0) ed = -ed;
                e.sum = (e.sum + ed > sum_max) ? sum_max : e.sum + ed;
                e.mx  = (ed > e.mx) ? ed : e.mx;
                e.cnt = e.cnt + ((ed != 0) ? 1 : 0);
                e.sq  = (e.sq + ed * ed > sq_max) ? sq_max : e.sq + ed * ed;
                acc++;
                si++;
            end
            cyc++;
        end
        n_chk++;
        if (acc != n) begin
            n_fail++;
            $display("FAIL accept_budget[%0d]: accepted %0d required %0d", idx, acc, n);
        end
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        start_v[idx] = poke;
        n_chk++;
        if (ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_flags[%0d]: ready=%b busy=%b required ready=0 busy=1", idx, ready_v[idx], busy_v[idx]);
        end
        @(negedge clk);
        start_v[idx] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (sum_a[idx] !== 32'(e.sum) || max_a[idx] !== 16'(e.mx) || cnt_a[idx] !== 16'(e.cnt) || done_v[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL latency2[%0d]: sum=%0d max=%0d cnt=%0d done=%b required %0d %0d %0d 0",
                     idx, sum_a[idx], max_a[idx], cnt_a[idx], done_v[idx], e.sum, e.mx, e.cnt);
        end
        @(negedge clk);
        n_chk++;
        if (done_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0) begin
            n_fail++;
            $display("FAIL done_latency[%0d]: done=%b busy=%b required done=1 busy=0", idx, done_v[idx], busy_v[idx]);
        end
        g = sb_q.pop_front();
        n_chk++;
        if (sum_a[idx] !== 32'(g.sum) || max_a[idx] !== 16'(g.mx) || cnt_a[idx] !== 16'(g.cnt)) begin
            n_fail++;
            $display("FAIL result[%0d]: sum=%0d max=%0d cnt=%0d required %0d %0d %0d",
                     idx, sum_a[idx], max_a[idx], cnt_a[idx], g.sum, g.mx, g.cnt);
        end
`ifdef APPROX_ERR_SQ_EN
        n_chk++;
        if (sq_a[idx] !== 48'(g.sq)) begin
            n_fail++;
            $display("FAIL sq_sum[%0d]: got %0d required %0d", idx, sq_a[idx], g.sq);
        end
`endif
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (ready_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 ||
                sum_a[i] !== 32'd0 || max_a[i] !== 16'd0 || cnt_a[i] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: rdy/busy/done=%b%b%b sum=%0d max=%0d cnt=%0d required all 0",
                         i, ready_v[i], busy_v[i], done_v[i], sum_a[i], max_a[i], cnt_a[i]);
            end
        end
    endtask

    task automatic test_exact();
        sx[0] = 255; sy[0] = 255; sz[0] = 65025;
        sx[1] = 0;   sy[1] = 0;   sz[1] = 0;
        sx[2] = 17;  sy[2] = 3;   sz[2] = 51;
        sx[3] = 128; sy[3] = 2;   sz[3] = 256;
        vlen = 0;
        open_window(0);
        run_window(0, 4, 32, 1'b0);
    endtask

    task automatic test_mixed();
        sx[0] = 10;  sy[0] = 10; sz[0] = 90;
        sx[1] = 200; sy[1] = 3;  sz[1] = 610;
        sx[2] = 1;   sy[2] = 1;  sz[2] = 1;
        vlen = 0;
        open_window(1);
        run_window(1, 3, 32, 1'b0);
        n_chk++;
        if (sum_a[1] !== 32'd20 || max_a[1] !== 16'd10 || cnt_a[1] !== 16'd2) begin
            n_fail++;
            $display("FAIL mixed_const: sum=%0d max=%0d cnt=%0d required 20 10 2", sum_a[1], max_a[1], cnt_a[1]);
        end
    endtask

    task automatic test_saturate();
        sx[0] = 0; sy[0] = 0; sz[0] = 65535;
        sx[1] = 0; sy[1] = 0; sz[1] = 65535;
        vlen = 0;
        open_window(2);
        run_window(2, 2, 16, 1'b0);
        n_chk++;
        if (sum16 !== 16'hFFFF || max_a[2] !== 16'hFFFF || cnt_a[2] !== 16'd2) begin
            n_fail++;
            $display("FAIL saturate: sum=%0d max=%0d cnt=%0d required 65535 65535 2", sum16, max_a[2], cnt_a[2]);
        end
    endtask

    task automatic test_gaps();
        sx[0] = 3;   sy[0] = 5;   sz[0] = 14;
        sx[1] = 250; sy[1] = 250; sz[1] = 0;
        sx[2] = 9;   sy[2] = 9;   sz[2] = 81;
        sx[3] = 100; sy[3] = 7;   sz[3] = 800;
        vpat[0] = 1; vpat[1] = 0; vpat[2] = 0; vpat[3] = 1; vpat[4] = 1; vpat[5] = 0; vpat[6] = 1;
        vlen = 7;
        open_window(0);
        run_window(0, 4, 32, 1'b0);
        vlen = 0;
    endtask

    task automatic test_start_ignored();
        sx[0] = 12; sy[0] = 12; sz[0] = 100;
        sx[1] = 1;  sy[1] = 2;  sz[1] = 3;
        sx[2] = 7;  sy[2] = 7;  sz[2] = 49;
        sx[3] = 40; sy[3] = 40; sz[3] = 1000;
        open_window(0);
        run_window(0, 4, 32, 1'b1);
        open_window(0);
        n_chk++;
        if (sum_a[0] !== 32'd0 || max_a[0] !== 16'd0 || cnt_a[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL restart_clear: sum=%0d max=%0d cnt=%0d required 0 0 0", sum_a[0], max_a[0], cnt_a[0]);
        end
        sx[0] = 2; sy[0] = 2; sz[0] = 5;
        sx[1] = 3; sy[1] = 3; sz[1] = 9;
        sx[2] = 4; sy[2] = 4; sz[2] = 10;
        sx[3] = 5; sy[3] = 5; sz[3] = 40;
        run_window(0, 4, 32, 1'b0);
    endtask

    task automatic test_abort_reset();
        open_window(3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1; x = 8'd255; y = 8'd255; z = 16'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (ready_v[3] !== 1'b0 || busy_v[3] !== 1'b0 || done_v[3] !== 1'b0 ||
            sum_a[3] !== 32'd0 || max_a[3] !== 16'd0 || cnt_a[3] !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_reset: rdy/busy/done=%b%b%b sum=%0d max=%0d cnt=%0d required all 0",
                     ready_v[3], busy_v[3], done_v[3], sum_a[3], max_a[3], cnt_a[3]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sx[i] = i * 30 + 5;
            sy[i] = 255 - i * 20;
            sz[i] = ((i * 30 + 5) * (255 - i * 20)) ^ (i * 7);
        end
        open_window(3);
        run_window(3, 8, 32, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_exact();
        test_mixed();
        test_saturate();
        test_gaps();
        test_start_ignored();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
